// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the 5-stage pipeline stall/flush sequencer.
//   ctrl_state_e : sequencer FSM state encoding
//   ctrl_out_t   : bundle of every per-cycle pipeline control output
//   DEF_*        : default parameter values for pipeline_ctrl
//   runOutputs() : control outputs of a RUN-style cycle
//   runNext()    : next state of a RUN-style cycle
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
    logic memwb_bubble;
    logic mdu_go;
  } ctrl_out_t;

  // Priority of a RUN-style cycle: mem wait > MDU start > redirect > load-use.
  // A redirect squashes the decode instruction, so any load-use hazard it
  // raised is moot and the redirect wins.
  function automatic ctrl_out_t runOutputs(input logic memWait,
                                           input logic mduReq,
                                           input logic redirect,
                                           input logic loadUse);
    ctrl_out_t o;
    o = '0;
    if (memWait) begin
      o.memwb_en     = 1'b1;
      o.memwb_bubble = 1'b1;
    end else if (mduReq) begin
      o.mdu_go       = 1'b1;
      o.exmem_en     = 1'b1;
      o.exmem_bubble = 1'b1;
      o.memwb_en     = 1'b1;
    end else begin
      o.pc_en    = 1'b1;
      o.ifid_en  = 1'b1;
      o.idex_en  = 1'b1;
      o.exmem_en = 1'b1;
      o.memwb_en = 1'b1;
      if (redirect) begin
        o.ifid_flush = 1'b1;
        o.idex_flush = 1'b1;
      end else if (loadUse) begin
        o.pc_en      = 1'b0;
        o.ifid_en    = 1'b0;
        o.idex_flush = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic ctrl_state_e runNext(input logic memWait,
                                          input logic mduReq);
    if (memWait) return MEM_WAIT;
    if (mduReq)  return MDU_BUSY;
    return RUN;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Handshake/control bundle between the pipeline datapath and pipeline_ctrl.
//   Requests  (master -> slave): load_use, redirect, mem_req, mem_ready,
//                                mdu_req, mdu_done
//   Controls  (slave -> master): mdu_go, pc_en, ifid_en, idex_en, exmem_en,
//                                memwb_en, ifid_flush, idex_flush,
//                                exmem_bubble, memwb_bubble
//   Status    (slave -> master): stall_cnt[CNT_W], mem_timeout
// The sequencer is the slave; the datapath (or a bench) is the master.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if
  import riscv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             load_use;
  logic             redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             mdu_req;
  logic             mdu_done;

  logic             mdu_go;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_bubble;
  logic             memwb_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  modport master (
    output load_use, redirect, mem_req, mem_ready, mdu_req, mdu_done,
    input  mdu_go, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_bubble, memwb_bubble,
           stall_cnt, mem_timeout
  );

  modport slave (
    input  load_use, redirect, mem_req, mem_ready, mdu_req, mdu_done,
    output mdu_go, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_bubble, memwb_bubble,
           stall_cnt, mem_timeout
  );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline. Merges load-use,
// EX redirect, data-memory wait and MUL/DIV handshakes into per-register
// enables, flush/bubble controls and the PC enable. Outputs are Mealy.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipeline_ctrl_if.slave (requests in, controls/status out)
// Parameters:
//   CNT_W       : stall_cnt width
//   MEM_TIMEOUT : stall cycles of one memory access before a forced advance
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_waitNext;
  logic              r_memTimeout;
  logic              w_timeoutHit;
  logic              w_memWait;
  ctrl_out_t         w_out;
  logic [CNT_W-1:0]  w_stallCnt;

  // The wait counter holds the number of stall cycles already spent on the
  // current access, so the RUN cycle that detects the wait loads 1. When it
  // reaches MEM_TIMEOUT-1 the current cycle is the MEM_TIMEOUT-th stall and
  // the access is abandoned. A cycle that leaves MEM_WAIT or MDU_BUSY is
  // decoded exactly like a RUN cycle; in the MDU done cycle mdu_req is
  // masked because it still reflects the instruction that is leaving EX.
  always_comb begin
    w_out        = '0;
    w_nextState  = r_state;
    w_waitNext   = '0;
    w_timeoutHit = 1'b0;
    w_memWait    = bus.mem_req & ~bus.mem_ready;
    case (r_state)
      RUN: begin
        w_out       = runOutputs(w_memWait, bus.mdu_req, bus.redirect, bus.load_use);
        w_nextState = runNext(w_memWait, bus.mdu_req);
      end
      MEM_WAIT: begin
        w_timeoutHit = ~bus.mem_ready & (r_waitCnt == WAIT_LAST);
        if (~bus.mem_ready & ~w_timeoutHit) begin
          w_out       = runOutputs(1'b1, 1'b0, 1'b0, 1'b0);
          w_waitNext  = r_waitCnt + 1'b1;
          w_nextState = MEM_WAIT;
        end else begin
          w_out       = runOutputs(1'b0, bus.mdu_req, bus.redirect, bus.load_use);
          w_nextState = runNext(1'b0, bus.mdu_req);
        end
      end
      MDU_BUSY: begin
        if (bus.mdu_done) begin
          w_out       = runOutputs(w_memWait, 1'b0, bus.redirect, bus.load_use);
          w_nextState = runNext(w_memWait, 1'b0);
        end else begin
          w_out        = runOutputs(1'b0, 1'b1, 1'b0, 1'b0);
          w_out.mdu_go = 1'b0;
        end
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
    if ((r_state != MEM_WAIT) && (w_nextState == MEM_WAIT)) begin
      w_waitNext = WAIT_W'(1);
    end
    if (rst) begin
      w_out        = '0;
      w_timeoutHit = 1'b0;
    end
  end

  // State, wait counter and the sticky timeout flag. Reset abandons any
  // pending memory wait or MDU operation without side effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitNext;
      if (w_timeoutHit) begin
        r_memTimeout <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~w_out.pc_en),
    .count (w_stallCnt)
  );

  assign bus.mdu_go       = w_out.mdu_go;
  assign bus.pc_en        = w_out.pc_en;
  assign bus.ifid_en      = w_out.ifid_en;
  assign bus.idex_en      = w_out.idex_en;
  assign bus.exmem_en     = w_out.exmem_en;
  assign bus.memwb_en     = w_out.memwb_en;
  assign bus.ifid_flush   = w_out.ifid_flush;
  assign bus.idex_flush   = w_out.idex_flush;
  assign bus.exmem_bubble = w_out.exmem_bubble;
  assign bus.memwb_bubble = w_out.memwb_bubble;
  assign bus.stall_cnt    = w_stallCnt;
  assign bus.mem_timeout  = r_memTimeout;

endmodule
